// File: rtl/div_unit.sv
// Signed 32-bit divider, one restoring shift-subtract step per clock; LO=quotient, HI=remainder.
// Latency: 34 edges start to DivDone. A start request is accepted only in IDLE; requests while busy are dropped.
module div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        DivCtrl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        DivBusy,
    output logic        DivDone,
    output logic        DivZero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] dvd;      // |A| shifting out, quotient bits shifting in
    logic [31:0] dvs;
    logic [31:0] rem;
    logic        sign_q;
    logic        sign_r;
    logic [4:0]  cnt;
    logic        start;
    logic        zero_req;
    logic [32:0] trial;
    logic [32:0] diff;
    logic        qbit;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    always_comb begin
        start    = (state == IDLE) && DivCtrl && (B != 32'd0);
        zero_req = (state == IDLE) && DivCtrl && (B == 32'd0);
        // 0x80000000 negates to itself, which is exactly its unsigned magnitude
        abs_a    = A[31] ? (~A + 32'd1) : A;
        abs_b    = B[31] ? (~B + 32'd1) : B;
        trial    = {rem, dvd[31]};
        diff     = trial - {1'b0, dvs};
        qbit     = ~diff[32];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == 5'd31) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dvd     <= 32'd0;
            dvs     <= 32'd0;
            rem     <= 32'd0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            cnt     <= 5'd0;
            HI      <= 32'd0;
            LO      <= 32'd0;
            DivDone <= 1'b0;
            DivZero <= 1'b0;
        end else begin
            DivDone <= 1'b0;
            DivZero <= zero_req;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd    <= abs_a;
                        dvs    <= abs_b;
                        rem    <= 32'd0;
                        sign_r <= A[31];
                        sign_q <= A[31] ^ B[31];
                        cnt    <= 5'd0;
                    end
                end
                RUN: begin
                    rem <= qbit ? diff[31:0] : trial[31:0];
                    dvd <= {dvd[30:0], qbit};
                    cnt <= cnt + 5'd1;
                end
                DONE: begin
                    LO      <= sign_q ? (32'd0 - dvd) : dvd;
                    HI      <= sign_r ? (32'd0 - rem) : rem;
                    DivDone <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign DivBusy = (state != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: edge-accurate handshake timing, sign cases, divide-by-zero, abort and busy drop.
module tb_div_unit;

    logic        clock;
    logic        reset;
    logic        DivCtrl;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        DivBusy;
    logic        DivDone;
    logic        DivZero;

    int checks = 0;
    int errors = 0;

    div_unit dut (
        .clock   (clock),
        .reset   (reset),
        .DivCtrl (DivCtrl),
        .A       (A),
        .B       (B),
        .HI      (HI),
        .LO      (LO),
        .DivBusy (DivBusy),
        .DivDone (DivDone),
        .DivZero (DivZero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs driven then are taken at the next edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Full division from E0 through E34. inject=1 raises DivCtrl with 9/3 so it is seen at E5 (must be ignored).
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi, input bit inject);
        DivCtrl = 1'b1;
        A = a;
        B = b;
        step();                                   // E0
        DivCtrl = 1'b0;
        A = 32'h5A5A_1234;
        B = 32'h0000_0003;
        check({tag, " busy_e0"}, {31'd0, DivBusy}, 32'd1);
        for (int k = 1; k <= 32; k++) begin
            if (inject && k == 4) begin
                DivCtrl = 1'b1;
                A = 32'd9;
                B = 32'd3;
            end
            step();                               // Ek
            if (inject && k == 5) DivCtrl = 1'b0;
            check($sformatf("%s busy_e%0d", tag, k), {31'd0, DivBusy}, 32'd1);
            check($sformatf("%s done_e%0d", tag, k), {31'd0, DivDone}, 32'd0);
            check($sformatf("%s zero_e%0d", tag, k), {31'd0, DivZero}, 32'd0);
        end
        step();                                   // E33
        check({tag, " done_e33"}, {31'd0, DivDone}, 32'd1);
        check({tag, " busy_e33"}, {31'd0, DivBusy}, 32'd0);
        check({tag, " zero_e33"}, {31'd0, DivZero}, 32'd0);
        check({tag, " lo"}, LO, exp_lo);
        check({tag, " hi"}, HI, exp_hi);
        step();                                   // E34
        check({tag, " done_e34"}, {31'd0, DivDone}, 32'd0);
        check({tag, " lo_hold"}, LO, exp_lo);
        check({tag, " hi_hold"}, HI, exp_hi);
    endtask

    initial begin
        reset   = 1'b1;
        DivCtrl = 1'b0;
        A       = 32'd0;
        B       = 32'd0;
        step();
        step();
        check("rst hi", HI, 32'd0);
        check("rst lo", LO, 32'd0);
        check("rst busy", {31'd0, DivBusy}, 32'd0);
        check("rst done", {31'd0, DivDone}, 32'd0);
        check("rst zero", {31'd0, DivZero}, 32'd0);
        reset = 1'b0;

        // Accepted on the first edge after reset release
        run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

        // Divide by zero: single DivZero pulse, results untouched
        DivCtrl = 1'b1;
        A = 32'd7;
        B = 32'd0;
        step();                                   // E0
        DivCtrl = 1'b0;
        check("dz zero_e0", {31'd0, DivZero}, 32'd1);
        check("dz busy_e0", {31'd0, DivBusy}, 32'd0);
        check("dz done_e0", {31'd0, DivDone}, 32'd0);
        check("dz hi_e0", HI, 32'd2);
        check("dz lo_e0", LO, 32'd14);
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("dz zero_e%0d", k), {31'd0, DivZero}, 32'd0);
            check($sformatf("dz busy_e%0d", k), {31'd0, DivBusy}, 32'd0);
            check($sformatf("dz done_e%0d", k), {31'd0, DivDone}, 32'd0);
        end
        check("dz hi", HI, 32'd2);
        check("dz lo", LO, 32'd14);

        run_div("dm7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_div("d7_m2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
        run_div("dm100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0);
        run_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        run_div("min_div_min", 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0);
        run_div("big_u", 32'h7FFF_FFFF, 32'h0001_0000, 32'h0000_7FFF, 32'h0000_FFFF, 1'b0);
        run_div("ignore", 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);

        // Abort mid-RUN with reset sampled at E10
        DivCtrl = 1'b1;
        A = 32'd100;
        B = 32'd7;
        step();                                   // E0
        DivCtrl = 1'b0;
        for (int k = 1; k <= 9; k++) step();
        reset = 1'b1;
        step();                                   // E10
        reset = 1'b0;
        check("abort busy_e10", {31'd0, DivBusy}, 32'd0);
        check("abort hi_e10", HI, 32'd0);
        check("abort lo_e10", LO, 32'd0);
        for (int k = 11; k <= 40; k++) begin
            step();
            check($sformatf("abort done_e%0d", k), {31'd0, DivDone}, 32'd0);
            check($sformatf("abort busy_e%0d", k), {31'd0, DivBusy}, 32'd0);
        end
        check("abort hi", HI, 32'd0);
        check("abort lo", LO, 32'd0);

        run_div("d9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
